// File: rtl/cpen391_pio_pkg.sv
// Register map shared by the LED/GPIO blink PIO and its users.
// Word addresses on the lightweight Avalon-MM bus.
package cpen391_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_BLINK  = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_OUT    = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/cpen391_blink_timer.sv
// Programmable prescaler producing the shared blink phase.
// A zero period freezes the phase high so blinking bits stay lit.
module cpen391_blink_timer #(
  parameter int PRESC_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] period,
  input  logic               restart,
  output logic               phase
);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart || period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpen391_led_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle and per-bit
// hardware blink. Zero-wait-state reads.
module cpen391_led_pio_blink #(
  parameter int                 WIDTH        = 10,
  parameter int                 PRESC_W      = 26,
  parameter logic [WIDTH-1:0]   DATA_RESET   = '0,
  parameter logic [PRESC_W-1:0] PERIOD_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  import cpen391_pio_pkg::*;

  logic               wr;
  logic               restart;
  logic               phase;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   blink_en;
  logic [PRESC_W-1:0] period;
  logic               unused_bits;

  assign wr          = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign restart     = wr && (address == ADDR_PERIOD);
  assign unused_bits = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= DATA_RESET;
      blink_en <= '0;
      period   <= PERIOD_RESET;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data     <= wd;
        ADDR_SET:    data     <= data | wd;
        ADDR_CLR:    data     <= data & ~wd;
        ADDR_TOGGLE: data     <= data ^ wd;
        ADDR_BLINK:  blink_en <= wd;
        ADDR_PERIOD: period   <= writedata[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  cpen391_blink_timer #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .period  (period),
    .restart (restart),
    .phase   (phase)
  );

  // Blinking bits follow DATA while phase is high, dark otherwise.
  assign out_port = (data & ~blink_en)
                  | (data & blink_en & {WIDTH{phase}});

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]   = data;
      ADDR_BLINK:  readdata[WIDTH-1:0]   = blink_en;
      ADDR_PERIOD: readdata[PRESC_W-1:0] = period;
      ADDR_STATUS: readdata[STATUS_PHASE_BIT] = phase;
      ADDR_OUT:    readdata[WIDTH-1:0]   = out_port;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpen391_led_pio_blink.sv
// Directed bench for the blink PIO: stimulus queues expectations,
// a negedge monitor compares them against readdata / out_port.
module tb_cpen391_led_pio_blink;

  import cpen391_pio_pkg::*;

  localparam int               W    = 10;
  localparam int               PW   = 26;
  localparam logic [W-1:0]     DRST = 10'h2A5;
  localparam logic [PW-1:0]    PRST = 26'd7;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  cpen391_led_pio_blink #(
    .WIDTH        (W),
    .PRESC_W      (PW),
    .DATA_RESET   (DRST),
    .PERIOD_RESET (PRST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_out;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          passed = 0;
  int          total  = 0;
  bit          done   = 1'b0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = mon_e.is_out ? {{(32-W){1'b0}}, out_port} : readdata;
      total++;
      if (mon_act === mon_e.exp) passed++;
      else $display("FAIL %s: got %h expected %h",
                    mon_e.name, mon_act, mon_e.exp);
    end
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] e,
                     input string n);
    total++;
    if (act === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, e);
  endtask

  function automatic void exp_rd(input logic [31:0] e, input string n);
    exp_t x;
    x.is_out = 1'b0; x.exp = e; x.name = n;
    sb.push_back(x);
  endfunction

  function automatic void exp_out(input logic [31:0] e, input string n);
    exp_t x;
    x.is_out = 1'b1; x.exp = e; x.name = n;
    sb.push_back(x);
  endfunction

  task automatic cyc(input logic cs, input logic wn,
                     input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e,
                    input string n);
    cyc(1'b1, 1'b1, a, 32'h0);
    exp_rd(e, n);
  endtask

  logic [15:0] ph3;
  logic        ph;

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete");
      $finish;
    end
  end

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = ADDR_DATA;
    writedata  = 32'h0;
    ph3        = 16'h0F0F;

    #1;
    chk({{(32-W){1'b0}}, out_port}, 32'h2A5, "rst_out_async");

    rd(ADDR_DATA, 32'h2A5, "rst_data");
    exp_out(32'h2A5, "rst_out");
    rd(ADDR_STATUS, 32'h1, "rst_status");
    rd(ADDR_PERIOD, 32'h7, "rst_period");
    reset = 1'b0;

    wr(ADDR_DATA, 32'h0F0);
    wr(ADDR_SET, 32'h003);
    wr(ADDR_CLR, 32'h010);
    wr(ADDR_TOGGLE, 32'h201);
    rd(ADDR_DATA, 32'h2E2, "rmw_data");
    exp_out(32'h2E2, "rmw_out");
    rd(ADDR_SET, 32'h0, "rd_set");
    rd(ADDR_CLR, 32'h0, "rd_clr");
    rd(ADDR_TOGGLE, 32'h0, "rd_toggle");

    wr(ADDR_DATA, 32'hFFFF_FFFF);
    rd(ADDR_DATA, 32'h3FF, "wide_data");
    rd(ADDR_OUT, 32'h3FF, "wide_outreg");
    exp_out(32'h3FF, "wide_out");
    wr(ADDR_PERIOD, 32'hFFFF_FFFF);
    rd(ADDR_PERIOD, 32'h03FF_FFFF, "wide_period");
    rd(ADDR_STATUS, 32'h1, "wide_status");

    wr(ADDR_BLINK, 32'h00F);
    wr(ADDR_PERIOD, 32'd3);
    for (int k = 0; k < 16; k++) begin
      ph = ph3[k];
      if (k[0]) rd(ADDR_OUT, ph ? 32'h3FF : 32'h3F0, "p3_outreg");
      else      rd(ADDR_STATUS, {31'b0, ph}, "p3_status");
      exp_out(ph ? 32'h3FF : 32'h3F0, "p3_out");
    end

    wr(ADDR_PERIOD, 32'd3);
    cyc(1'b0, 1'b1, ADDR_DATA, 32'h0);
    exp_out(32'h3FF, "rw_pre0");
    cyc(1'b0, 1'b1, ADDR_DATA, 32'h0);
    exp_out(32'h3FF, "rw_pre1");
    wr(ADDR_PERIOD, 32'd5);
    exp_out(32'h3FF, "rw_pre2");
    for (int j = 0; j < 10; j++) begin
      ph = (j < 6);
      rd(ADDR_STATUS, {31'b0, ph}, "p5_status");
      exp_out(ph ? 32'h3FF : 32'h3F0, "p5_out");
    end

    cyc(1'b1, 1'b1, ADDR_STATUS, 32'h0);
    reset = 1'b1;
    exp_rd(32'h1, "mid_rst_status");
    exp_out(32'h2A5, "mid_rst_out");
    rd(ADDR_PERIOD, 32'h7, "mid_rst_period");
    rd(ADDR_BLINK, 32'h0, "mid_rst_blink");
    reset = 1'b0;
    rd(ADDR_DATA, 32'h2A5, "post_rst_data");

    wr(ADDR_BLINK, 32'h3FF);
    wr(ADDR_DATA, 32'h155);
    wr(ADDR_PERIOD, 32'd0);
    for (int k = 0; k < 1000; k++) begin
      rd(ADDR_STATUS, 32'h1, "p0_status");
      exp_out(32'h155, "p0_out");
    end

    cyc(1'b0, 1'b1, ADDR_DATA, 32'h0);
    @(negedge clk);
    #1;
    chk(sb.size(), 32'd0, "sb_drained");
    chk(passed, total, "all_passed");
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
